vx_gbar_arbiter: RTL
====================

Name: vx_gbar_arbiter

Overview:
- Cluster-level global-barrier controller that sits between the per-core scheduler gbar request ports and the broadcast gbar response bus.
- Each cycle it round-robin arbitrates one core's barrier-arrival request and records it in a per-barrier-ID arrival mask.
- When a barrier's arrival count reaches the requested size, it clears that mask and broadcasts a one-cycle release response to all cores.

Parameters:
- NUM_REQS, 4: number of requesting cores, ≥1.
- NUM_BARRIERS, 8: number of barrier IDs, ≥2.
- NB_WIDTH, CLOG2(NUM_BARRIERS): barrier ID width (derived).
- NC_WIDTH, LOG2UP(NUM_REQS): core index / size_m1 width (derived).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  NUM_REQS  per-core arrival request valid
- req_id  in  NUM_REQS*NB_WIDTH  per-core barrier ID, packed, core i at [i*NB_WIDTH +: NB_WIDTH]
- req_size_m1  in  NUM_REQS*NC_WIDTH  per-core participant count minus 1, packed
- req_ready  out  NUM_REQS  one-hot grant; request i is consumed when req_valid[i] && req_ready[i]
- rsp_valid  out  1  release broadcast pulse
- rsp_id  out  NB_WIDTH  released barrier ID
- pending_ids  out  NUM_BARRIERS  bit b = mask[b] != 0
- busy  out  1  any pending_ids bit set or rsp_valid high

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset. All state updates occur on posedge clk.
- Reset: all arrival masks = 0; rr pointer = 0; rsp_valid = 0; rsp_id = 0; pending_ids = 0; busy = 0. Reset mid-operation drops all arrivals with no response.
- Arbitration: combinational. req_ready is one-hot and selects the first valid index at or after rr pointer, wrapping modulo NUM_REQS. req_ready is all-zero when no req_valid is set.
- req_ready may depend on req_valid. Requesters must hold valid, id and size stable until granted.
- Pointer update: after a grant to index g, pointer = (g+1) mod NUM_REQS. With no grant, the pointer is unchanged.
- Accept: on grant of core g for barrier ID b with size s, let cnt = popcount(mask[b]) before the update.
  - If cnt == s, release: mask[b] <= 0; next cycle rsp_valid = 1 and rsp_id = b.
  - Otherwise mask[b][g] <= 1 and rsp_valid = 0 next cycle.
  - Comparison uses the NC_WIDTH bits of cnt.
- Latency: accepted in cycle T, rsp_valid in cycle T+1 for exactly one cycle. Back-to-back releases produce consecutive pulses. There is no response back-pressure.
- size_m1 = 0: immediate release at T+1; the mask is never set.
- Duplicate arrival: core g granted for ID b while mask[b][g] == 1 is a protocol error (RUNTIME_ASSERT). The mask stays unchanged and it counts as no new arrival. It still releases if cnt == s.
- Independent IDs: arrivals for different IDs do not interact. Releasing ID b never touches mask[b'] for b' != b.
- Since one grant occurs per cycle, a release and a new arrival never target the same ID in the same cycle. An arrival for b in cycle T+1 after a release of b in T starts a fresh barrier generation.
- pending_ids and busy are registered from the post-update masks and rsp_valid, so they reflect state at the same edge as rsp_valid.
- Width rules: popcount width CLOG2(NUM_REQS+1); req_id ≥ NUM_BARRIERS is out of range and asserted.

Test Plan:
- Reset, idle: hold reset 2 cycles, then release it with no valids -> req_ready=0000, rsp_valid=0, busy=0, pending_ids=0 for 10 cycles.
- 4-core barrier: cores 0..3 each request id=3, size_m1=3, one per cycle -> pending_ids=0x08 after first grant; rsp_valid=1, rsp_id=3 exactly one cycle after core 3's grant; mask[3]=0 and busy=0 one cycle after that.
- Round-robin fairness: all 4 cores assert valid simultaneously for id=1, size_m1=3, starting with pointer=0 -> grants in order 0,1,2,3 on consecutive cycles; single rsp pulse id=1 in the cycle after core 3's grant.
- Pointer wrap: pointer=2 and req_valid=1011 -> grant order 3,0,1.
- size_m1=0: core 2 requests id=5 -> rsp_valid=1, rsp_id=5 next cycle; pending_ids stays 0.
- Interleaved IDs plus mid-operation reset: cores 0,1 arrive on id=0 (size_m1=1) interleaved with core 2 on id=7 (size_m1=2) -> only id=0 releases. Then assert reset -> pending_ids=0 and no rsp pulse for id=7 afterwards.

Source files
------------

// File: rtl/vx_gbar_arbiter.sv
// ============================================================================
//  Module   : vx_gbar_arbiter
//  Brief    : Cluster global-barrier controller with round-robin arrival arbitration
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vx_gbar_arbiter #(
  parameter int NUM_REQS     = 4,
  parameter int NUM_BARRIERS = 8,
  parameter int NB_WIDTH     = $clog2(NUM_BARRIERS),
  parameter int NC_WIDTH     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQS-1:0]          req_valid,
  input  logic [NUM_REQS*NB_WIDTH-1:0] req_id,
  input  logic [NUM_REQS*NC_WIDTH-1:0] req_size_m1,
  output logic [NUM_REQS-1:0]          req_ready,
  output logic                         rsp_valid,
  output logic [NB_WIDTH-1:0]          rsp_id,
  output logic [NUM_BARRIERS-1:0]      pending_ids,
  output logic                         busy
);

  localparam int c_CNT_WIDTH = $clog2(NUM_REQS + 1);

  logic [NC_WIDTH-1:0]     r_ptr;
  logic [NUM_REQS-1:0]     r_mask [NUM_BARRIERS];
  logic                    r_rsp_valid;
  logic [NB_WIDTH-1:0]     r_rsp_id;
  logic [NUM_BARRIERS-1:0] r_pending;
  logic                    r_busy;

  logic                    w_found;
  logic [NC_WIDTH-1:0]     w_gidx;
  logic [NC_WIDTH-1:0]     w_idx;
  logic [NUM_REQS-1:0]     w_grant;
  logic [NB_WIDTH-1:0]     w_sel_id;
  logic [NC_WIDTH-1:0]     w_sel_size;
  logic [NUM_REQS-1:0]     w_sel_mask;
  logic                    w_id_ok;
  logic [c_CNT_WIDTH-1:0]  w_cnt;
  logic                    w_hit;
  logic                    w_release;
  logic [NUM_REQS-1:0]     w_mask_nxt [NUM_BARRIERS];
  logic [NUM_BARRIERS-1:0] w_pending_nxt;
  logic                    w_unused_cnt;

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      w_idx = NC_WIDTH'((int'(r_ptr) + k) % NUM_REQS);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gidx  = w_idx;
      end
    end
  end

  always_comb begin
    w_grant         = '0;
    w_grant[w_gidx] = w_found;
  end

  assign w_sel_id   = req_id[int'(w_gidx)*NB_WIDTH +: NB_WIDTH];
  assign w_sel_size = req_size_m1[int'(w_gidx)*NC_WIDTH +: NC_WIDTH];

  generate
    if ((1 << NB_WIDTH) == NUM_BARRIERS) begin : g_id_full
      assign w_id_ok = 1'b1;
    end else begin : g_id_range
      assign w_id_ok = (w_sel_id < NB_WIDTH'(NUM_BARRIERS));
    end
  endgenerate

  assign w_sel_mask = w_id_ok ? r_mask[w_sel_id] : '0;

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      w_cnt = w_cnt + c_CNT_WIDTH'(w_sel_mask[i]);
    end
  end

  // Only the low NC_WIDTH bits of the arrival count take part in the match.
  assign w_hit        = (w_cnt[NC_WIDTH-1:0] == w_sel_size);
  assign w_unused_cnt = ^w_cnt;

  always_comb begin
    w_release = 1'b0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      w_mask_nxt[b] = r_mask[b];
    end
    if (w_found && w_id_ok) begin
      if (w_hit) begin
        w_mask_nxt[w_sel_id] = '0;
        w_release            = 1'b1;
      end else begin
        w_mask_nxt[w_sel_id][w_gidx] = 1'b1;
      end
    end
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      w_pending_nxt[b] = |w_mask_nxt[b];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        r_mask[b] <= '0;
      end
      r_ptr       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_pending   <= '0;
      r_busy      <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        r_mask[b] <= w_mask_nxt[b];
      end
      if (w_found) begin
        r_ptr <= (w_gidx == NC_WIDTH'(NUM_REQS - 1)) ? '0 : w_gidx + 1'b1;
      end
      r_rsp_valid <= w_release;
      if (w_release) begin
        r_rsp_id <= w_sel_id;
      end
      r_pending <= w_pending_nxt;
      r_busy    <= (|w_pending_nxt) | w_release;
    end
  end

  // Protocol checks: barrier ID in range, no repeated arrival from one core.
  always_ff @(posedge clk) begin
    if (!reset && w_found) begin
      assert (w_id_ok);
      assert (!w_sel_mask[w_gidx]);
    end
  end

  assign req_ready   = w_grant;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign pending_ids = r_pending;
  assign busy        = r_busy;

endmodule

`default_nettype wire
